// File: rtl/data_mem_ctrl_pkg.sv
// Shared definitions for the data memory controller: FSM encoding and
// default geometry.
package data_mem_ctrl_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      IDLE  = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 16;
   localparam int DEF_ADDR_W = 10;
   localparam int DEF_DEPTH  = 1024;

endpackage

// File: rtl/data_mem_ctrl.sv
// Single-port byte-writable data memory with a power-up clear sequence and a
// one-cycle registered response for every accepted request.
module data_mem_ctrl
   import data_mem_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_we,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   input  logic [DATA_W/8-1:0] req_be,
   output logic                rsp_valid,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                busy,
   output state_t              state
);

   localparam int                NB    = DATA_W / 8;
   localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);

   // Handshake: a request transfers on a rising edge where req_valid and
   // req_ready are both 1; its response is a single rsp_valid cycle right
   // after, and the requester can never stall it.

   logic [DATA_W-1:0] mem [DEPTH];
   state_t            next_state;
   logic [ADDR_W-1:0] clr_cnt;
   logic              accept;
   logic              in_range;
   logic [NB-1:0]     mem_be;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] rd_q;
   logic              rsp_rd;

   assign req_ready = (state == IDLE);
   assign busy      = (state == CLEAR);
   assign accept    = req_valid && req_ready;
   assign in_range  = ({1'b0, req_addr} < LIMIT);

   always_comb begin
      next_state = state;
      mem_be     = '0;
      mem_addr   = req_addr;
      mem_wdata  = req_wdata;
      case (state)
         CLEAR: begin
            mem_be    = '1;
            mem_addr  = clr_cnt;
            mem_wdata = '0;
            if (clr_cnt == LAST) next_state = IDLE;
         end
         IDLE: begin
            if (accept && req_we && in_range) mem_be = req_be;
         end
         default: next_state = CLEAR;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= CLEAR;
         clr_cnt   <= '0;
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_rd    <= 1'b0;
      end else begin
         state <= next_state;
         if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
         rsp_valid <= accept;
         rsp_err   <= accept && !in_range;
         rsp_rd    <= accept && !req_we && in_range;
      end
   end

   // Array has no reset; the CLEAR walk is what zeroes it.
   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
      rd_q <= mem[mem_addr];
   end

   assign rsp_rdata = rsp_rd ? rd_q : '0;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed and short random checks of the data memory controller against a
// byte-lane memory model with a response scoreboard.
module tb_data_mem_ctrl;
  import data_mem_ctrl_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1000;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [1:0]    req_be;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          busy;
  state_t        state;

  data_mem_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_be    (req_be),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .state     (state)
  );

  int n_vec = 0;
  int n_err = 0;
  int n_rsp = 0;
  logic mon_en = 1'b0;
  logic [DW:0] exp_q[$];
  logic [DW:0] mon_e;
  logic [DW-1:0] model [0:(1<<AW)-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // scoreboard: pop one expected {err, rdata} per response pulse
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (rsp_valid) begin
        n_rsp++;
        if (exp_q.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 32'd0);
        else begin
          mon_e = exp_q.pop_front();
          check("rsp", 32'({rsp_err, rsp_rdata}), 32'(mon_e));
        end
      end else begin
        check("rsp_idle_zero", 32'({rsp_err, rsp_rdata}), 32'd0);
      end
    end
  end

  // driver tasks
  task automatic send(input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] data, input logic [1:0] be);
    @(negedge clk);
    check("req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = data;
    req_be    = be;
    if (int'(addr) >= DEPTH) exp_q.push_back({1'b1, {DW{1'b0}}});
    else if (we) begin
      for (int i = 0; i < 2; i++)
        if (be[i]) model[addr][8*i +: 8] = data[8*i +: 8];
      exp_q.push_back({1'b0, {DW{1'b0}}});
    end else exp_q.push_back({1'b0, model[addr]});
  endtask

  task automatic drain();
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_in_reset();
    #1;
    check("rst_busy",      32'(busy),      32'd1);
    check("rst_ready",     32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err",   32'(rsp_err),   32'd0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
  endtask

  task automatic release_and_wait_clear();
    int cycles;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < (1<<AW); i++) model[i] = '0;
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (busy && cycles < 2*DEPTH);
    check("clear_cycles", 32'(cycles), 32'(DEPTH));
    check("state_idle", 32'(state), 32'(IDLE));
    check("ready_idle", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    rst = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    #1 rst = 1'b1;
    check_in_reset();
    release_and_wait_clear();
    mon_en = 1'b1;

    // cleared memory reads back zero at both ends and the middle
    send(1'b0, AW'(0), '0, 2'b00);
    send(1'b0, AW'(DEPTH/2), '0, 2'b00);
    send(1'b0, AW'(DEPTH-1), '0, 2'b00);
    drain();

    // full write then read back
    send(1'b1, AW'(5), 16'hBEEF, 2'b11);
    send(1'b0, AW'(5), '0, 2'b00);
    drain();

    // byte lanes: expect 0xAB34, and be=00 leaves it alone
    send(1'b1, AW'(7), 16'h1234, 2'b11);
    send(1'b1, AW'(7), 16'hAB00, 2'b10);
    send(1'b0, AW'(7), '0, 2'b00);
    send(1'b1, AW'(7), 16'h5555, 2'b00);
    send(1'b0, AW'(7), '0, 2'b00);
    drain();
    check("byte_lane_model", 32'(model[7]), 32'h0000AB34);

    // out-of-range accesses error out and touch nothing
    send(1'b0, AW'(1000), '0, 2'b00);
    send(1'b1, AW'(1023), 16'hFFFF, 2'b11);
    send(1'b0, AW'(999), '0, 2'b00);
    drain();

    // alternating write/read on one address, 8 back-to-back requests
    n0 = n_rsp;
    for (int i = 0; i < 4; i++) begin
      send(1'b1, AW'(3), 16'(16'h1111 * (i + 1)), 2'b11);
      send(1'b0, AW'(3), '0, 2'b00);
    end
    drain();
    check("alt_rsp_count", 32'(n_rsp - n0), 32'd8);

    // random burst over a small window plus out-of-range addresses
    for (int i = 0; i < 40; i++) begin
      send(1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? AW'($urandom_range(990, 1023)) : AW'($urandom_range(0, 15)),
           DW'($urandom_range(0, 16'hFFFF)), 2'($urandom_range(0, 3)));
    end
    drain();

    // reset with a response in flight, then again mid-CLEAR
    send(1'b1, AW'(2), 16'h5A5A, 2'b11);
    send(1'b0, AW'(2), '0, 2'b00);
    drain();
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(2); req_be = 2'b00;
    @(posedge clk);
    #1 req_valid = 1'b0;
    check("pending_rsp", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    exp_q.delete();
    check_in_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("mid_clear_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    check_in_reset();
    release_and_wait_clear();
    send(1'b0, AW'(2), '0, 2'b00);
    send(1'b0, AW'(DEPTH-1), '0, 2'b00);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16: data word width in bits, a multiple of 8.
REQ-002 The block SHALL have parameter ADDR_W, default 10: word-address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 1024: number of words, with 1 <= DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-007 The block SHALL have port req_ready, output, 1 bit: the block accepts a request this cycle.
REQ-008 The block SHALL have port req_we, input, 1 bit: 1 = write, 0 = read.
REQ-009 The block SHALL have port req_addr, input, ADDR_W bits: word address.
REQ-010 The block SHALL have port req_wdata, input, DATA_W bits: write data.
REQ-011 The block SHALL have port req_be, input, DATA_W/8 bits: byte enables; bit i selects bits [8i+7:8i].
REQ-012 The block SHALL have port rsp_valid, output, 1 bit: one-cycle response pulse.
REQ-013 The block SHALL have port rsp_rdata, output, DATA_W bits: read data, valid only while rsp_valid=1.
REQ-014 The block SHALL have port rsp_err, output, 1 bit: the response is for an out-of-range address.
REQ-015 The block SHALL have port busy, output, 1 bit: the init-clear sequence is in progress.

Function
REQ-016 The FSM SHALL have two states, CLEAR and IDLE; reset enters CLEAR with the clear counter at 0.
REQ-017 In CLEAR, the block SHALL write 0 to word clr_cnt each cycle, increment clr_cnt, hold busy=1 and req_ready=0, and enter IDLE after writing word DEPTH-1.
REQ-018 Clearing DEPTH words SHALL take exactly DEPTH cycles; busy SHALL fall on the edge that writes word DEPTH-1.
REQ-019 In IDLE, req_ready SHALL be 1 and busy SHALL be 0; a request is accepted when req_valid && req_ready.
REQ-020 An accepted write with req_addr < DEPTH SHALL update only the enabled byte lanes at the accepting edge.
REQ-021 A write with req_be=0 SHALL leave memory unchanged but still be acknowledged.
REQ-022 An accepted read SHALL present the addressed word on rsp_rdata with rsp_valid=1 in the cycle after acceptance (1-cycle latency, registered output).
REQ-023 Every accepted request, read or write, SHALL produce exactly one rsp_valid pulse, one cycle after acceptance; write responses SHALL carry rsp_rdata=0.
REQ-024 A request with req_addr >= DEPTH SHALL not modify memory and SHALL respond with rsp_err=1 and rsp_rdata=0.
REQ-025 rsp_err and rsp_rdata SHALL be 0 whenever rsp_valid=0.
REQ-026 Back-to-back requests SHALL be accepted every cycle; a read accepted the cycle after a write to the same address SHALL return the newly written data.
REQ-027 There SHALL be no response backpressure; the requester always consumes rsp_valid.

Reset
REQ-028 While rst=1, outputs SHALL be: busy=1, req_ready=0, rsp_valid=0, rsp_err=0, rsp_rdata=0.
REQ-029 The memory array itself SHALL not be reset asynchronously; it is zeroed by the CLEAR sequence.
REQ-030 Assertion of rst mid-CLEAR or mid-IDLE SHALL abort the current operation, drop any pending response, and restart CLEAR from word 0.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding (CLEAR, IDLE) and the default DATA_W, ADDR_W and DEPTH constants.
REQ-032 The block SHALL be a single module with no sub-module; the array SHALL be inferred as single-port synchronous RAM with per-byte write enable.

Verification
REQ-033 Test: reset, then count cycles until busy=0 -> exactly DEPTH cycles; a read of words 0, DEPTH/2 and DEPTH-1 returns 0.
REQ-034 Test: write 0xBEEF to addr 5 with be=2'b11, then read addr 5 -> rsp_valid one cycle later with rdata=0xBEEF and rsp_err=0.
REQ-035 Test: write 0x1234 to addr 7 with be=11, then write 0xAB00 with be=10, then read -> 0xAB34; a further write with be=00 leaves 0xAB34.
REQ-036 Test: with DEPTH=1000, read addr 1000 and write addr 1023 -> rsp_err=1 and rdata=0; then read addr 999 -> 0 (memory unchanged).
REQ-037 Test: assert rst at cycle 300 of CLEAR after writing addr 2 pre-reset -> busy=1 for a full DEPTH cycles after release, and addr 2 reads 0.
REQ-038 Test: continuous alternating write/read to addr 3 over 8 cycles -> 8 rsp_valid pulses, and each read returns the preceding write's data.
